// File: rtl/rsa4k_pkg.sv
// Shared definitions for the rsa4k word-serial stream front/back end:
// FSM states, default widths and operand index constants.
package rsa4k_pkg;

   localparam int WIDTH_DEF = 4096;
   localparam int WORD_DEF  = 32;

   localparam logic [1:0] OP_MSG = 2'd0;
   localparam logic [1:0] OP_EXP = 2'd1;
   localparam logic [1:0] OP_MOD = 2'd2;

   typedef enum logic [1:0] {
      LOAD   = 2'd0,
      ARM    = 2'd1,
      RUN    = 2'd2,
      UNLOAD = 2'd3
   } state_t;

endpackage

// File: rtl/rsa4k_stream_io_if.sv
// Word stream bundle: upstream s_* (operand words in) and downstream m_* (result words out).
// The slave modport is the rsa4k_stream_io view; master is the bus/DMA view.
interface rsa4k_stream_io_if #(
   parameter int WORD = 32
);
   logic            s_valid;
   logic            s_ready;
   logic [WORD-1:0] s_data;
   logic            m_valid;
   logic            m_ready;
   logic [WORD-1:0] m_data;
   logic            m_last;

   modport master (
      output s_valid, s_data, m_ready,
      input  s_ready, m_valid, m_data, m_last
   );

   modport slave (
      input  s_valid, s_data, m_ready,
      output s_ready, m_valid, m_data, m_last
   );
endinterface

// File: rtl/rsa4k_word_shifter.sv
// WIDTH-bit register written one WORD at a time (or loaded whole) with a word-indexed read mux.
module rsa4k_word_shifter #(
   parameter  int WIDTH  = 4096,
   parameter  int WORD   = 32,
   localparam int NWORDS = WIDTH / WORD,
   localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic [IW-1:0]    widx,
   input  logic [WORD-1:0]  wdata,
   input  logic             ld,
   input  logic [WIDTH-1:0] ld_data,
   input  logic [IW-1:0]    ridx,
   output logic [WORD-1:0]  rdata,
   output logic [WIDTH-1:0] q
);

   // NOTE: this is a flop register, not a RAM: it is reset so a discarded
   // partial load never leaks into the next job's operands.
   always_ff @(posedge clk) begin
      if (!reset) begin
         q <= '0;
      end else if (ld) begin
         q <= ld_data;
      end else if (we) begin
         q[widx*WORD +: WORD] <= wdata;
      end
   end

   assign rdata = q[ridx*WORD +: WORD];

endmodule

// File: rtl/rsa4k_stream_io.sv
// Word-serial front/back end for rsa4k: loads message/exponent/modulus, runs the core,
// streams the result out. Optional modulus check under macro RSA4K_MODCHK_EN.
module rsa4k_stream_io
   import rsa4k_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int WORD  = WORD_DEF
) (
   input  logic             clk,
   input  logic             reset,
   rsa4k_stream_io_if.slave io,
   output logic             busy,
   output logic             core_go,
   output logic [WIDTH-1:0] core_message,
   output logic [WIDTH-1:0] core_exponent,
   output logic [WIDTH-1:0] core_modulus,
   input  logic [WIDTH-1:0] core_cypher,
   input  logic             core_done
`ifdef RSA4K_MODCHK_EN
   ,
   output logic             mod_err
`endif
);

   localparam int NWORDS = WIDTH / WORD;
   localparam int IW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

   state_t           state_q, state_d;
   logic [IW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic             busy_q, busy_d;
   logic             res_ld;
   logic [WIDTH-1:0] res_ld_data;
   logic [WORD-1:0]  res_word;
   logic             s_hs;
   logic [WORD-1:0]  msg_rd_unused, exp_rd_unused, mod_rd_unused;
   logic [WIDTH-1:0] res_q_unused;
`ifdef RSA4K_MODCHK_EN
   logic             mod_err_q, mod_err_d;
`endif

   assign s_hs = (state_q == LOAD) && io.s_valid;

   // NOTE: every combinational output gets a default before the case so no
   // path through the FSM leaves a signal unassigned and infers a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      busy_d      = busy_q;
      res_ld      = 1'b0;
      res_ld_data = '0;
      core_go     = 1'b0;
      io.s_ready  = 1'b0;
      io.m_valid  = 1'b0;
      io.m_last   = 1'b0;
`ifdef RSA4K_MODCHK_EN
      mod_err_d   = mod_err_q;
`endif
      case (state_q)
         LOAD: begin
            io.s_ready = 1'b1;
            if (io.s_valid) begin
               busy_d = 1'b1;
`ifdef RSA4K_MODCHK_EN
               if (cnt_q == '0 && op_q == OP_MSG) mod_err_d = 1'b0;
`endif
               if (cnt_q == LAST_IDX) begin
                  cnt_d = '0;
                  if (op_q == OP_MOD) begin
                     op_d    = OP_MSG;
                     state_d = ARM;
                  end else begin
                     op_d = op_q + 2'd1;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ARM: begin
`ifdef RSA4K_MODCHK_EN
            // An even modulus (zero included) has no valid result: skip the core.
            if (!core_modulus[0]) begin
               res_ld    = 1'b1;
               mod_err_d = 1'b1;
               state_d   = UNLOAD;
            end else if (!core_done) begin
               state_d = RUN;
            end
`else
            // Wait out a done left high by the previous job before launching.
            if (!core_done) state_d = RUN;
`endif
         end
         RUN: begin
            core_go = 1'b1;
            if (core_done) begin
               res_ld      = 1'b1;
               res_ld_data = core_cypher;
               state_d     = UNLOAD;
            end
         end
         UNLOAD: begin
            io.m_valid = 1'b1;
            io.m_last  = (cnt_q == LAST_IDX);
            if (io.m_ready) begin
               if (cnt_q == LAST_IDX) begin
                  cnt_d   = '0;
                  busy_d  = 1'b0;
                  state_d = LOAD;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= LOAD;
         cnt_q   <= '0;
         op_q    <= OP_MSG;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         busy_q  <= busy_d;
      end
   end

`ifdef RSA4K_MODCHK_EN
   always_ff @(posedge clk) begin
      if (!reset) mod_err_q <= 1'b0;
      else        mod_err_q <= mod_err_d;
   end
   assign mod_err = mod_err_q;
`endif

   assign busy      = busy_q;
   assign io.m_data = (state_q == UNLOAD) ? res_word : '0;

   rsa4k_word_shifter #(.WIDTH(WIDTH), .WORD(WORD)) u_msg (
      .clk(clk), .reset(reset),
      .we(s_hs && op_q == OP_MSG), .widx(cnt_q), .wdata(io.s_data),
      .ld(1'b0), .ld_data('0), .ridx('0),
      .rdata(msg_rd_unused), .q(core_message)
   );

   rsa4k_word_shifter #(.WIDTH(WIDTH), .WORD(WORD)) u_exp (
      .clk(clk), .reset(reset),
      .we(s_hs && op_q == OP_EXP), .widx(cnt_q), .wdata(io.s_data),
      .ld(1'b0), .ld_data('0), .ridx('0),
      .rdata(exp_rd_unused), .q(core_exponent)
   );

   rsa4k_word_shifter #(.WIDTH(WIDTH), .WORD(WORD)) u_mod (
      .clk(clk), .reset(reset),
      .we(s_hs && op_q == OP_MOD), .widx(cnt_q), .wdata(io.s_data),
      .ld(1'b0), .ld_data('0), .ridx('0),
      .rdata(mod_rd_unused), .q(core_modulus)
   );

   rsa4k_word_shifter #(.WIDTH(WIDTH), .WORD(WORD)) u_res (
      .clk(clk), .reset(reset),
      .we(1'b0), .widx('0), .wdata('0),
      .ld(res_ld), .ld_data(res_ld_data), .ridx(cnt_q),
      .rdata(res_word), .q(res_q_unused)
   );

endmodule

// File: tb/tb_rsa4k_stream_io.sv
// Scoreboard bench for rsa4k_stream_io with a behavioural rsa4k stub (done after 20 go cycles).
// Define RSA4K_MODCHK_EN to also exercise the even-modulus rejection path.
module tb_rsa4k_stream_io;

   localparam int WIDTH = 4096;
   localparam int WORD  = 32;
   localparam int NW    = WIDTH / WORD;

   typedef struct {
      logic [WORD-1:0] data;
      logic            last;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   rsa4k_stream_io_if #(.WORD(WORD)) io ();

   logic             busy, core_go, core_done;
   logic [WIDTH-1:0] core_message, core_exponent, core_modulus, core_cypher;
`ifdef RSA4K_MODCHK_EN
   logic             mod_err;
`endif

   rsa4k_stream_io #(.WIDTH(WIDTH), .WORD(WORD)) dut (
      .clk(clk),
      .reset(reset),
      .io(io),
      .busy(busy),
      .core_go(core_go),
      .core_message(core_message),
      .core_exponent(core_exponent),
      .core_modulus(core_modulus),
      .core_cypher(core_cypher),
      .core_done(core_done)
`ifdef RSA4K_MODCHK_EN
      ,
      .mod_err(mod_err)
`endif
   );

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_in = 0;
   int   n_out = 0;
   bit   bp_en = 1'b0;
   bit   go_seen = 1'b0;
   logic stale_done = 1'b0;
   exp_t sb[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic logic [31:0] modexp(input longint unsigned b, input longint unsigned e,
                                          input longint unsigned m);
      longint unsigned r = 1;
      b = b % m;
      while (e != 0) begin
         if (e[0]) r = (r * b) % m;
         b = (b * b) % m;
         e = e >> 1;
      end
      return r[31:0];
   endfunction

   // Behavioural rsa4k: done 20 cycles after go, held until go drops.
   logic stub_done;
   int   stub_cnt;
   assign core_done = stub_done | stale_done;
   always @(posedge clk) begin
      if (!reset) begin
         stub_done   <= 1'b0;
         stub_cnt    <= 0;
         core_cypher <= '0;
      end else if (stub_done) begin
         if (!core_go) stub_done <= 1'b0;
      end else if (core_go) begin
         if (stub_cnt == 19) begin
            stub_done   <= 1'b1;
            stub_cnt    <= 0;
            core_cypher <= WIDTH'(modexp(core_message[31:0], core_exponent[31:0], core_modulus[31:0]));
         end else begin
            stub_cnt <= stub_cnt + 1;
         end
      end
   end

   // Downstream ready: always 1, or a coin flip per cycle when backpressure is on.
   initial begin
      io.m_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         io.m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor: counts handshakes, compares result words against the scoreboard.
   initial begin
      logic            stall_prev = 1'b0;
      logic [WORD-1:0] prev_data  = '0;
      logic            prev_last  = 1'b0;
      exp_t            e;
      forever begin
         @(negedge clk);
         if (core_go) go_seen = 1'b1;
         if (io.s_valid && io.s_ready) n_in++;
         if (io.m_valid) begin
            if (stall_prev) begin
               check("m_data_stable", 64'(io.m_data), 64'(prev_data));
               check("m_last_stable", 64'(io.m_last), 64'(prev_last));
            end
            if (io.m_ready) begin
               n_out++;
               if (sb.size() == 0) begin
                  check("unexpected_word", 64'(io.m_data), 64'hDEAD_0000_0000_0000);
               end else begin
                  e = sb.pop_front();
                  check("m_data", 64'(io.m_data), 64'(e.data));
                  check("m_last", 64'(io.m_last), 64'(e.last));
               end
            end
            stall_prev = !io.m_ready;
            prev_data  = io.m_data;
            prev_last  = io.m_last;
         end else begin
            stall_prev = 1'b0;
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Drivers change inputs 1 time unit after posedge; the monitor samples on negedge.
   task automatic send_word(input logic [WORD-1:0] w, input bit gaps);
      bit ok;
      if (gaps) begin
         repeat ($urandom_range(0, 1)) begin
            io.s_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      io.s_valid = 1'b1;
      io.s_data  = w;
      for (int t = 0; t < 2000; t++) begin
         @(negedge clk);
         ok = io.s_ready;
         @(posedge clk);
         #1;
         if (ok) return;
      end
      check("s_ready_timeout", 64'd0, 64'd1);
   endtask

   task automatic load_words(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n,
                             input int count, input bit gaps);
      logic [31:0] vals [3];
      int          sent = 0;
      vals = '{m, e, n};
      for (int op = 0; op < 3; op++) begin
         for (int k = 0; k < NW; k++) begin
            if (sent < count) send_word((k == 0) ? vals[op] : '0, gaps);
            sent++;
         end
      end
      io.s_valid = 1'b0;
      io.s_data  = '0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_s_ready"}, 64'(io.s_ready), 64'd1);
      check({tag, "_m_valid"}, 64'(io.m_valid), 64'd0);
      check({tag, "_m_last"},  64'(io.m_last),  64'd0);
      check({tag, "_m_data"},  64'(io.m_data),  64'd0);
      check({tag, "_busy"},    64'(busy),       64'd0);
      check({tag, "_core_go"}, 64'(core_go),    64'd0);
      check({tag, "_operands_zero"},
            64'((core_message == '0) && (core_exponent == '0) && (core_modulus == '0)), 64'd1);
`ifdef RSA4K_MODCHK_EN
      check({tag, "_mod_err"}, 64'(mod_err), 64'd0);
`endif
   endtask

   task automatic pulse_reset(input string tag);
      io.s_valid = 1'b0;
      reset = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_reset_values(tag);
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   task automatic run_job(input string tag, input logic [31:0] m, input logic [31:0] e,
                          input logic [31:0] n, input bit gaps, input int stale_cycles,
                          input bit expect_launch);
      logic [31:0] r;
      int          in0, out0;
      bit          drained = 1'b0;
      r = expect_launch ? modexp(m, e, n) : 32'd0;
      for (int k = 0; k < NW; k++) sb.push_back('{data: (k == 0) ? r : '0, last: (k == NW - 1)});
      in0  = n_in;
      out0 = n_out;
      go_seen = 1'b0;
      if (stale_cycles > 0) stale_done = 1'b1;
      load_words(m, e, n, 3 * NW, gaps);
      if (expect_launch) begin
         for (int i = 0; i < stale_cycles; i++) begin
            @(negedge clk);
            check({tag, "_go_held_by_stale_done"}, 64'(core_go), 64'd0);
            @(posedge clk);
            #1;
         end
         stale_done = 1'b0;
         @(negedge clk);
         check({tag, "_go_arm_cycle"}, 64'(core_go), 64'd0);
         @(negedge clk);
         check({tag, "_go_launch"}, 64'(core_go), 64'd1);
         check({tag, "_core_message"},  64'(core_message  == WIDTH'(m)), 64'd1);
         check({tag, "_core_exponent"}, 64'(core_exponent == WIDTH'(e)), 64'd1);
         check({tag, "_core_modulus"},  64'(core_modulus  == WIDTH'(n)), 64'd1);
      end
      for (int t = 0; t < 20000; t++) begin
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            drained = 1'b1;
            break;
         end
      end
      check({tag, "_drained"}, 64'(drained), 64'd1);
      @(negedge clk);
      check({tag, "_busy_after"},    64'(busy),       64'd0);
      check({tag, "_s_ready_after"}, 64'(io.s_ready), 64'd1);
      check({tag, "_m_valid_after"}, 64'(io.m_valid), 64'd0);
      check({tag, "_words_in"},  64'(n_in - in0),   64'(3 * NW));
      check({tag, "_words_out"}, 64'(n_out - out0), 64'(NW));
      if (!expect_launch) check({tag, "_go_never"}, 64'(go_seen), 64'd0);
`ifdef RSA4K_MODCHK_EN
      check({tag, "_mod_err"}, 64'(mod_err), 64'(!expect_launch));
`endif
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit saw_go = 1'b0;
      io.s_valid = 1'b0;
      io.s_data  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Busy must stay low while nothing has been accepted, even with m_ready high.
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;

      run_job("job1", 32'd8, 32'd13, 32'd77, 1'b0, 0, 1'b1);
      run_job("job2", 32'd50, 32'd37, 32'd77, 1'b0, 5, 1'b1);

      bp_en = 1'b1;
      run_job("job3_bp", 32'd8, 32'd13, 32'd77, 1'b1, 0, 1'b1);
      bp_en = 1'b0;

      // Abort mid-RUN.
      load_words(32'd8, 32'd13, 32'd77, 3 * NW, 1'b0);
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (core_go) begin
            saw_go = 1'b1;
            break;
         end
      end
      check("abort_run_go_seen", 64'(saw_go), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      pulse_reset("rst_mid_run");

      // Abort after 100 modulus words.
      load_words(32'd8, 32'd13, 32'd77, 2 * NW + 100, 1'b0);
      pulse_reset("rst_partial");

      run_job("job4_after_reset", 32'd8, 32'd13, 32'd77, 1'b0, 0, 1'b1);

`ifdef RSA4K_MODCHK_EN
      run_job("modchk_even", 32'd8, 32'd13, 32'd76, 1'b0, 0, 1'b0);
      run_job("modchk_odd", 32'd8, 32'd13, 32'd77, 1'b0, 0, 1'b1);
`endif

      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
